fsm_event_counter: RTL and testbench

//   Downstream stage of the two-output sequence FSM: consumes its z1/z2 outputs and counts

---
 rtl/fsm_event_counter_pkg.sv | 29 ++
 rtl/fsm_event_counter_if.sv | 53 +++++
 rtl/fsm_event_counter_edge_counter.sv | 82 ++++++++
 rtl/fsm_event_counter.sv | 81 ++++++++
 tb/tb_fsm_event_counter.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fsm_event_counter_pkg.sv
// Shared definitions for the z1/z2 event counter.
// Holds the default counter width and the per-edge window action decode
// (clear beats snapshot beats plain counting), so both channels resolve
// priority identically.
package fsm_event_counter_pkg;

    localparam int DEFAULT_CNT_WIDTH = 8;

    // What a channel does to its counting window on a given clock edge.
    typedef enum logic [1:0] {
        ACT_COUNT = 2'd0,
        ACT_SNAP  = 2'd1,
        ACT_CLEAR = 2'd2
    } win_action_e;

    // Clear wins outright; a snapshot only happens when no clear is present.
    function automatic win_action_e decode_action(input logic clear, input logic snap);
        if (clear) begin
            return ACT_CLEAR;
        end
        else if (snap) begin
            return ACT_SNAP;
        end
        else begin
            return ACT_COUNT;
        end
    endfunction

endpackage

// File: rtl/fsm_event_counter_if.sv
// Signal bundle between the sequence FSM / readout logic and the event counter.
// The master side drives the FSM outputs and control strobes; the slave side
// (the counter) returns live counts, sticky saturation flags and snapshots.
interface fsm_event_counter_if
    import fsm_event_counter_pkg::*;
#(
    parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
) ();

    logic                 z1;
    logic                 z2;
    logic                 enable;
    logic                 clear;
    logic                 snap_req;
    logic [CNT_WIDTH-1:0] cnt_z1;
    logic [CNT_WIDTH-1:0] cnt_z2;
    logic                 sat_z1;
    logic                 sat_z2;
    logic [CNT_WIDTH-1:0] snap_z1;
    logic [CNT_WIDTH-1:0] snap_z2;
    logic                 snap_valid;

    modport master (
        output z1,
        output z2,
        output enable,
        output clear,
        output snap_req,
        input  cnt_z1,
        input  cnt_z2,
        input  sat_z1,
        input  sat_z2,
        input  snap_z1,
        input  snap_z2,
        input  snap_valid
    );

    modport slave (
        input  z1,
        input  z2,
        input  enable,
        input  clear,
        input  snap_req,
        output cnt_z1,
        output cnt_z2,
        output sat_z1,
        output sat_z2,
        output snap_z1,
        output snap_z2,
        output snap_valid
    );

endinterface

// File: rtl/fsm_event_counter_edge_counter.sv
// One event-counter channel: detects 0->1 transitions of x and counts them
// into a saturating counter with a sticky saturation flag. A snapshot copies
// the count (including an increment landing on the same edge) into snap_val
// and restarts the window; a clear restarts the window without copying.
module fsm_event_counter_edge_counter
    import fsm_event_counter_pkg::*;
#(
    parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 x,
    input  logic                 enable,
    input  logic                 clear,
    input  logic                 snap,
    output logic [CNT_WIDTH-1:0] cnt,
    output logic                 sat,
    output logic [CNT_WIDTH-1:0] snap_val
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic                 x_q;
    logic                 rise;
    logic [CNT_WIDTH-1:0] cnt_inc;
    logic                 sat_hit;
    win_action_e          action;

    assign rise   = x & ~x_q;
    assign action = decode_action(clear, snap);

    // Previous-value register tracks x every edge, independent of enable/clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q <= 1'b0;
        end
        else begin
            x_q <= x;
        end
    end

    // Count after this edge's rise, holding at max and flagging the lost event.
    always_comb begin
        cnt_inc = cnt;
        sat_hit = 1'b0;
        if (enable && rise) begin
            if (cnt == CNT_MAX) begin
                sat_hit = 1'b1;
            end
            else begin
                cnt_inc = cnt + 1'b1;
            end
        end
    end

    // Window state: clear drops everything, snapshot captures then restarts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt      <= '0;
            sat      <= 1'b0;
            snap_val <= '0;
        end
        else begin
            case (action)
                ACT_CLEAR: begin
                    cnt <= '0;
                    sat <= 1'b0;
                end
                ACT_SNAP: begin
                    snap_val <= cnt_inc;
                    cnt      <= '0;
                    sat      <= 1'b0;
                end
                default: begin
                    cnt <= cnt_inc;
                    sat <= sat | sat_hit;
                end
            endcase
        end
    end

endmodule

// File: rtl/fsm_event_counter.sv
// Event counter downstream of the two-output sequence FSM.
// Counts rising edges of z1 and z2 into independent saturating counters and
// offers an atomic snapshot that also restarts the counting window.
// Build option: define EVCNT_SYNC_EN to pass z1/z2 through a two-flop
// synchronizer when the FSM lives on an unrelated clock (adds two edges of
// input-to-count latency).
module fsm_event_counter
    import fsm_event_counter_pkg::*;
#(
    parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset_n,
    fsm_event_counter_if.slave       bus
);

    logic z1_eff;
    logic z2_eff;

`ifdef EVCNT_SYNC_EN
    logic [1:0] z_meta;
    logic [1:0] z_sync;

    // Two-stage synchronizer for both FSM outputs; bit 0 is z1, bit 1 is z2.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            z_meta <= 2'b00;
            z_sync <= 2'b00;
        end
        else begin
            z_meta <= {bus.z2, bus.z1};
            z_sync <= z_meta;
        end
    end

    assign z1_eff = z_sync[0];
    assign z2_eff = z_sync[1];
`else
    assign z1_eff = bus.z1;
    assign z2_eff = bus.z2;
`endif

    fsm_event_counter_edge_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_counter_z1 (
        .clk      (clk),
        .reset_n  (reset_n),
        .x        (z1_eff),
        .enable   (bus.enable),
        .clear    (bus.clear),
        .snap     (bus.snap_req),
        .cnt      (bus.cnt_z1),
        .sat      (bus.sat_z1),
        .snap_val (bus.snap_z1)
    );

    fsm_event_counter_edge_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_counter_z2 (
        .clk      (clk),
        .reset_n  (reset_n),
        .x        (z2_eff),
        .enable   (bus.enable),
        .clear    (bus.clear),
        .snap     (bus.snap_req),
        .cnt      (bus.cnt_z2),
        .sat      (bus.sat_z2),
        .snap_val (bus.snap_z2)
    );

    // Snapshot strobe: one pulse per accepted request, suppressed by clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.snap_valid <= 1'b0;
        end
        else begin
            bus.snap_valid <= bus.snap_req & ~bus.clear;
        end
    end

endmodule

// File: tb/tb_fsm_event_counter.sv
// Scoreboard bench for fsm_event_counter (narrow 4-bit counters so that
// saturation is reached quickly). Stimulus pushes expected post-edge state
// and expected snapshots into queues; a monitor pops and compares.
module tb_fsm_event_counter;

    localparam int W        = 4;
    localparam int MAXCOUNT = (1 << W) - 1;

    typedef struct {
        int c1;
        int c2;
        bit s1;
        bit s2;
        int p1;
        int p2;
        bit v;
    } exp_t;

    typedef struct {
        int a;
        int b;
    } snap_t;

    logic clk;
    logic reset_n;

    exp_t  expQ[$];
    snap_t snapQ[$];

    int checkCount;
    int errorCount;

    // Reference model state: plain event counts per window
    int mC1, mC2, mSnap1, mSnap2;
    bit mS1, mS2, mPrev1, mPrev2;
    bit mD1a, mD1b, mD2a, mD2b;

    fsm_event_counter_if #(.CNT_WIDTH(W)) bus ();

    fsm_event_counter #(
        .CNT_WIDTH (W)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: one clock edge worth of behaviour
    task automatic modelStep(input bit rn, input bit z1, input bit z2,
                             input bit en, input bit clr, input bit snap);
        exp_t  e;
        snap_t s;
        bit    eff1, eff2, r1, r2, v;
        v = 1'b0;
        if (!rn) begin
            mC1 = 0; mC2 = 0; mS1 = 0; mS2 = 0;
            mSnap1 = 0; mSnap2 = 0; mPrev1 = 0; mPrev2 = 0;
            mD1a = 0; mD1b = 0; mD2a = 0; mD2b = 0;
        end
        else begin
`ifdef EVCNT_SYNC_EN
            eff1 = mD1b; mD1b = mD1a; mD1a = z1;
            eff2 = mD2b; mD2b = mD2a; mD2a = z2;
`else
            eff1 = z1;
            eff2 = z2;
`endif
            r1 = eff1 && !mPrev1;
            r2 = eff2 && !mPrev2;
            mPrev1 = eff1;
            mPrev2 = eff2;
            if (clr) begin
                mC1 = 0; mC2 = 0; mS1 = 0; mS2 = 0;
            end
            else begin
                if (en && r1) begin
                    if (mC1 == MAXCOUNT) mS1 = 1'b1;
                    else mC1 = mC1 + 1;
                end
                if (en && r2) begin
                    if (mC2 == MAXCOUNT) mS2 = 1'b1;
                    else mC2 = mC2 + 1;
                end
                if (snap) begin
                    mSnap1 = mC1; mSnap2 = mC2;
                    s.a = mC1; s.b = mC2;
                    snapQ.push_back(s);
                    mC1 = 0; mC2 = 0; mS1 = 0; mS2 = 0;
                    v = 1'b1;
                end
            end
        end
        e.c1 = mC1; e.c2 = mC2; e.s1 = mS1; e.s2 = mS2;
        e.p1 = mSnap1; e.p2 = mSnap2; e.v = v;
        expQ.push_back(e);
    endtask

    // Drive one cycle of inputs just after an edge and record expectations
    task automatic applyStimulus(input bit rn, input bit z1, input bit z2,
                                 input bit en, input bit clr, input bit snap);
        @(posedge clk);
        #2;
        reset_n      = rn;
        bus.z1       = z1;
        bus.z2       = z2;
        bus.enable   = en;
        bus.clear    = clr;
        bus.snap_req = snap;
        modelStep(rn, z1, z2, en, clr, snap);
    endtask

    // Compare all visible outputs against one expected post-edge state
    task automatic checkOutput(input exp_t e);
        checkCount++;
        if (bus.cnt_z1 !== W'(e.c1) || bus.cnt_z2 !== W'(e.c2) ||
            bus.sat_z1 !== e.s1 || bus.sat_z2 !== e.s2 ||
            bus.snap_z1 !== W'(e.p1) || bus.snap_z2 !== W'(e.p2) ||
            bus.snap_valid !== e.v) begin
            errorCount++;
            $display("[TB] FAIL outputs @%0t: got cnt=%0d/%0d sat=%b/%b snap=%0d/%0d v=%b, expected cnt=%0d/%0d sat=%b/%b snap=%0d/%0d v=%b",
                     $time, bus.cnt_z1, bus.cnt_z2, bus.sat_z1, bus.sat_z2,
                     bus.snap_z1, bus.snap_z2, bus.snap_valid,
                     e.c1, e.c2, e.s1, e.s2, e.p1, e.p2, e.v);
        end
    endtask

    // Monitor: per-cycle state check plus snapshot transaction check
    always @(posedge clk) begin
        exp_t  e;
        snap_t s;
        #1;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput(e);
        end
        if (bus.snap_valid === 1'b1) begin
            checkCount++;
            if (snapQ.size() == 0) begin
                errorCount++;
                $display("[TB] FAIL snapshot @%0t: got unexpected snap_valid with %0d/%0d, expected no snapshot",
                         $time, bus.snap_z1, bus.snap_z2);
            end
            else begin
                s = snapQ.pop_front();
                if (bus.snap_z1 !== W'(s.a) || bus.snap_z2 !== W'(s.b)) begin
                    errorCount++;
                    $display("[TB] FAIL snapshot @%0t: got %0d/%0d, expected %0d/%0d",
                             $time, bus.snap_z1, bus.snap_z2, s.a, s.b);
                end
            end
        end
    end

    initial begin
        checkCount = 0;
        errorCount = 0;
        reset_n      = 1'b0;
        bus.z1       = 1'b0;
        bus.z2       = 1'b0;
        bus.enable   = 1'b0;
        bus.clear    = 1'b0;
        bus.snap_req = 1'b0;
        modelStep(1'b0, 0, 0, 0, 0, 0);
        expQ.delete();

        // Reset held with z1 toggling, then release with z1 high
        for (int i = 0; i < 4; i++) applyStimulus(0, i[0], 0, 1, 0, 0);
        applyStimulus(1, 1, 0, 1, 0, 0);
        applyStimulus(1, 0, 0, 1, 1, 0);

        // Five z1 pulses, two z2 pulses (one simultaneous), then z1 held high
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 1, (i == 2), 1, 0, 0);
            applyStimulus(1, 0, 0, 1, 0, 0);
        end
        applyStimulus(1, 0, 1, 1, 0, 0);
        applyStimulus(1, 0, 0, 1, 0, 0);
        for (int i = 0; i < 20; i++) applyStimulus(1, 1, 0, 1, 0, 0);
        applyStimulus(1, 0, 0, 1, 1, 0);

        // Seventeen z2 rises saturate the narrow counter
        for (int i = 0; i < 17; i++) begin
            applyStimulus(1, 0, 1, 1, 0, 0);
            applyStimulus(1, 0, 0, 1, 0, 0);
        end
        applyStimulus(1, 0, 0, 1, 1, 0);

        // Three z1 rises, then snapshot on the edge of a fourth rise
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 1, 0, 1, 0, 0);
            applyStimulus(1, 0, 0, 1, 0, 0);
        end
        applyStimulus(1, 1, 0, 1, 0, 1);
        applyStimulus(1, 0, 0, 1, 0, 0);

        // Six z1 rises, then clear and snapshot together
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 1, 0, 1, 0, 0);
            applyStimulus(1, 0, 0, 1, 0, 0);
        end
        applyStimulus(1, 0, 0, 1, 1, 1);

        // Disabled rises are not counted; back-to-back snapshots
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 1, 1, 0, 0, 0);
            applyStimulus(1, 0, 0, 0, 0, 0);
        end
        applyStimulus(1, 1, 0, 1, 0, 1);
        applyStimulus(1, 0, 1, 1, 0, 1);
        applyStimulus(1, 1, 1, 1, 0, 1);

        // Reset mid-window discards counts
        applyStimulus(1, 0, 0, 1, 0, 0);
        applyStimulus(1, 1, 1, 1, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0);
        applyStimulus(1, 0, 0, 1, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 299) != 0),
                          1'($urandom), 1'($urandom),
                          ($urandom_range(0, 9) < 8),
                          ($urandom_range(0, 49) == 0),
                          ($urandom_range(0, 19) == 0));
        end
        applyStimulus(1, 0, 0, 1, 0, 0);

        // Drain the scoreboard with a bounded wait
        repeat (3) @(posedge clk);
        #3;
        checkCount++;
        if (expQ.size() != 0 || snapQ.size() != 0) begin
            errorCount++;
            $display("[TB] FAIL drain: got %0d state / %0d snapshot entries left, expected 0/0",
                     expQ.size(), snapQ.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, errorCount);
        $finish;
    end

endmodule
